vx_scoreboard_mp: RTL and testbench

- Multi-port, counter-based register scoreboard for the issue stage.
- Tracks outstanding register writes per (warp, register) using saturating pending counters, so multiple writes to the same rd can be in flight (WAW allowed).
- Accepts NUM_WB_PORTS independent writebacks per cycle and gates issue on RAW hazards and counter saturation.
- Exports a stall-cycle performance counter and a sticky underflow error flag.

---
 rtl/vx_scoreboard_mp_if.sv | 38 +++
 rtl/vx_scoreboard_mp.sv | 92 +++++++++
 tb/tb_vx_scoreboard_mp.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/vx_scoreboard_mp_if.sv
// Issue/writeback bundle for the multi-port register scoreboard.
interface vx_scoreboard_mp_if #(
   parameter int unsigned NUM_WARPS     = 4,
   parameter int unsigned NUM_REGS      = 64,
   parameter int unsigned NUM_WB_PORTS  = 2,
   parameter int unsigned PERF_CTR_BITS = 44
);
   localparam int unsigned WIDB = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
   localparam int unsigned RB   = $clog2(NUM_REGS);

   logic                           issue_valid;
   logic [WIDB-1:0]                issue_wid;
   logic                           issue_wb;
   logic [RB-1:0]                  issue_rd;
   logic [RB-1:0]                  issue_rs1;
   logic [RB-1:0]                  issue_rs2;
   logic [RB-1:0]                  issue_rs3;
   logic                           issue_ready;
   logic [NUM_WB_PORTS-1:0]        wb_valid;
   logic [NUM_WB_PORTS*WIDB-1:0]   wb_wid;
   logic [NUM_WB_PORTS*RB-1:0]     wb_rd;
   logic [NUM_WB_PORTS-1:0]        wb_eop;
   logic                           busy;
   logic                           underflow_err;
   logic [PERF_CTR_BITS-1:0]       stall_cnt;

   modport master (
      output issue_valid, issue_wid, issue_wb, issue_rd, issue_rs1, issue_rs2, issue_rs3,
      output wb_valid, wb_wid, wb_rd, wb_eop,
      input  issue_ready, busy, underflow_err, stall_cnt
   );

   modport slave (
      input  issue_valid, issue_wid, issue_wb, issue_rd, issue_rs1, issue_rs2, issue_rs3,
      input  wb_valid, wb_wid, wb_rd, wb_eop,
      output issue_ready, busy, underflow_err, stall_cnt
   );
endinterface

// File: rtl/vx_scoreboard_mp.sv
// Counter-based register scoreboard: per (warp, reg) saturating pending counters,
// multi-port writeback retirement, RAW/saturation issue gating, stall counter.
module vx_scoreboard_mp #(
   parameter int unsigned NUM_WARPS     = 4,
   parameter int unsigned NUM_REGS      = 64,
   parameter int unsigned NUM_WB_PORTS  = 2,
   parameter int unsigned CNT_BITS      = 2,
   parameter int unsigned PERF_CTR_BITS = 44
) (
   input  logic               clk,
   input  logic               reset,
   vx_scoreboard_mp_if.slave  bus
);
   localparam int unsigned WIDB = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
   localparam int unsigned RB   = $clog2(NUM_REGS);
   localparam int unsigned CMAX = (1 << CNT_BITS) - 1;
   localparam int unsigned SW   = CNT_BITS + $clog2(NUM_WB_PORTS) + 1;

   logic [NUM_WARPS-1:0][NUM_REGS-1:0][CNT_BITS-1:0] pend_q, pend_d;
   logic                     busy_q, busy_d;
   logic                     uf_q, uf_d;
   logic [PERF_CTR_BITS-1:0] stall_q, stall_d;
   logic                     issue_ready_c;
   logic                     issue_fire_c;
   logic [SW-1:0]            sum;

   // Hazard check from registered state only (no writeback bypass).
   always_comb begin
      issue_ready_c = 1'b1;
      if (bus.issue_rs1 != '0 && pend_q[bus.issue_wid][bus.issue_rs1] != '0)
         issue_ready_c = 1'b0;
      if (bus.issue_rs2 != '0 && pend_q[bus.issue_wid][bus.issue_rs2] != '0)
         issue_ready_c = 1'b0;
      if (bus.issue_rs3 != '0 && pend_q[bus.issue_wid][bus.issue_rs3] != '0)
         issue_ready_c = 1'b0;
      if (bus.issue_wb && bus.issue_rd != '0 &&
          pend_q[bus.issue_wid][bus.issue_rd] == CNT_BITS'(CMAX))
         issue_ready_c = 1'b0;
   end

   assign issue_fire_c = bus.issue_valid && issue_ready_c && bus.issue_wb && (bus.issue_rd != '0);

   // Counter update: +issue, -eop writebacks (summed over ports), clamp at zero on underflow.
   always_comb begin
      pend_d  = '0;
      uf_d    = uf_q;
      sum     = '0;
      stall_d = stall_q;
      if (bus.issue_valid && !issue_ready_c)
         stall_d = stall_q + PERF_CTR_BITS'(1);
      for (int w = 0; w < int'(NUM_WARPS); w++) begin
         for (int r = 1; r < int'(NUM_REGS); r++) begin
            sum = SW'(pend_q[w][r]);
            if (issue_fire_c && bus.issue_wid == WIDB'(w) && bus.issue_rd == RB'(r))
               sum = sum + SW'(1);
            for (int p = 0; p < int'(NUM_WB_PORTS); p++) begin
               if (bus.wb_valid[p] && bus.wb_eop[p] &&
                   bus.wb_wid[p*WIDB +: WIDB] == WIDB'(w) &&
                   bus.wb_rd[p*RB +: RB] == RB'(r))
                  sum = sum - SW'(1);
            end
            if (sum[SW-1]) begin
               pend_d[w][r] = '0;
               uf_d         = 1'b1;
            end else begin
               pend_d[w][r] = CNT_BITS'(sum);
            end
         end
      end
      busy_d = |pend_d;
   end

   // State registers; async reset drops all pending state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q  <= '0;
         busy_q  <= 1'b0;
         uf_q    <= 1'b0;
         stall_q <= '0;
      end else begin
         pend_q  <= pend_d;
         busy_q  <= busy_d;
         uf_q    <= uf_d;
         stall_q <= stall_d;
      end
   end

   assign bus.issue_ready   = issue_ready_c;
   assign bus.busy          = busy_q;
   assign bus.underflow_err = uf_q;
   assign bus.stall_cnt     = stall_q;
endmodule

// File: tb/tb_vx_scoreboard_mp.sv
// Random + directed bench for vx_scoreboard_mp with a queue-based scoreboard.
module tb_vx_scoreboard_mp;
   localparam int NW = 4;
   localparam int NR = 64;
   localparam int NP = 2;
   localparam int CB = 2;
   localparam int CMAX_M = 3;

   typedef struct {
      bit          ready;
      bit          busy;
      bit          uf;
      logic [43:0] stall;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t expq[$];

   int          pend_m [NW][NR];
   bit          uf_m;
   logic [43:0] stall_m;

   vx_scoreboard_mp_if #(.NUM_WARPS(NW), .NUM_REGS(NR), .NUM_WB_PORTS(NP), .PERF_CTR_BITS(44)) ifc ();

   vx_scoreboard_mp #(.NUM_WARPS(NW), .NUM_REGS(NR), .NUM_WB_PORTS(NP), .CNT_BITS(CB),
                      .PERF_CTR_BITS(44)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, want);
      end
   endtask

   // Monitor: compare DUT outputs away from the active edge.
   always @(negedge clk) begin
      if (expq.size() > 0) begin
         exp_t e;
         e = expq.pop_front();
         chk("issue_ready", 64'(ifc.issue_ready), 64'(e.ready));
         chk("busy", 64'(ifc.busy), 64'(e.busy));
         chk("underflow_err", 64'(ifc.underflow_err), 64'(e.uf));
         chk("stall_cnt", 64'(ifc.stall_cnt), 64'(e.stall));
      end
   end

   function automatic bit model_busy();
      for (int w = 0; w < NW; w++)
         for (int r = 0; r < NR; r++)
            if (pend_m[w][r] != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit model_ready(input int wid, input bit wb, input int rd,
                                      input int rs1, input int rs2, input int rs3);
      if (rs1 != 0 && pend_m[wid][rs1] > 0) return 1'b0;
      if (rs2 != 0 && pend_m[wid][rs2] > 0) return 1'b0;
      if (rs3 != 0 && pend_m[wid][rs3] > 0) return 1'b0;
      if (wb && rd != 0 && pend_m[wid][rd] >= CMAX_M) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void model_clear();
      foreach (pend_m[w, r]) pend_m[w][r] = 0;
      uf_m    = 1'b0;
      stall_m = '0;
   endfunction

   task automatic idle_inputs();
      ifc.issue_valid = 1'b0; ifc.issue_wid = '0; ifc.issue_wb = 1'b0;
      ifc.issue_rd = '0; ifc.issue_rs1 = '0; ifc.issue_rs2 = '0; ifc.issue_rs3 = '0;
      ifc.wb_valid = '0; ifc.wb_wid = '0; ifc.wb_rd = '0; ifc.wb_eop = '0;
   endtask

   // One cycle: drive, push expectation from the model, then advance the model.
   task automatic step(input bit v, input int wid, input bit wb, input int rd,
                       input int rs1, input int rs2, input int rs3,
                       input bit [1:0] wv, input int ww0, input int wr0,
                       input int ww1, input int wr1, input bit [1:0] we);
      exp_t e;
      bit   rdy;
      int   ww [NP];
      int   wr [NP];
      @(posedge clk); #1;
      ww[0] = ww0; ww[1] = ww1; wr[0] = wr0; wr[1] = wr1;
      ifc.issue_valid = v;  ifc.issue_wid = 2'(wid); ifc.issue_wb = wb;
      ifc.issue_rd = 6'(rd); ifc.issue_rs1 = 6'(rs1); ifc.issue_rs2 = 6'(rs2); ifc.issue_rs3 = 6'(rs3);
      ifc.wb_valid = wv; ifc.wb_eop = we;
      ifc.wb_wid = {2'(ww1), 2'(ww0)};
      ifc.wb_rd  = {6'(wr1), 6'(wr0)};
      rdy = model_ready(wid, wb, rd, rs1, rs2, rs3);
      e.ready = rdy; e.busy = model_busy(); e.uf = uf_m; e.stall = stall_m;
      expq.push_back(e);
      if (v && !rdy) stall_m = stall_m + 44'd1;
      if (v && rdy && wb && rd != 0) pend_m[wid][rd]++;
      for (int p = 0; p < NP; p++)
         if (wv[p] && we[p] && wr[p] != 0) pend_m[ww[p]][wr[p]]--;
      foreach (pend_m[w, r])
         if (pend_m[w][r] < 0) begin
            pend_m[w][r] = 0;
            uf_m = 1'b1;
         end
   endtask

   task automatic nop();
      step(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00);
   endtask

   // Reset asserted between edges and held across a sample point.
   task automatic pulse_reset();
      exp_t e;
      @(posedge clk); #1;
      idle_inputs();
      #1 reset = 1'b1;
      model_clear();
      e.ready = 1'b1; e.busy = 1'b0; e.uf = 1'b0; e.stall = '0;
      expq.push_back(e);
      #6 reset = 1'b0;
   endtask

   initial begin
      idle_inputs();
      model_clear();
      pulse_reset();

      // Issue then RAW on same warp, other warp independent.
      step(1, 1, 1, 5, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00);
      step(1, 1, 0, 0, 5, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00);
      step(1, 2, 0, 0, 5, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00);
      // Saturation on rd=7 with held stalls.
      repeat (3) step(1, 0, 1, 7, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00);
      repeat (3) step(1, 0, 1, 7, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00);
      // Dual-port retirement of rd=9.
      repeat (2) step(1, 0, 1, 9, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00);
      step(0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 9, 0, 9, 2'b11);
      step(1, 0, 0, 0, 0, 9, 0, 2'b00, 0, 0, 0, 0, 2'b00);
      // Drain rd=7 and rd=5 so busy falls.
      step(0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 7, 0, 7, 2'b11);
      step(0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 7, 1, 5, 2'b11);
      nop();
      // Simultaneous inc/dec nets out; non-eop beat has no effect.
      step(1, 0, 1, 4, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00);
      step(1, 0, 1, 4, 0, 0, 0, 2'b01, 0, 4, 0, 0, 2'b01);
      step(0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 4, 0, 0, 2'b00);
      step(1, 0, 0, 0, 4, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00);
      // Underflow is sticky until reset.
      step(0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 3, 3, 2'b10);
      nop(); nop();
      pulse_reset();
      nop();
      // Register 0 never tracked.
      step(1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00);
      step(0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 2, 0, 2'b11);
      nop();

      // Randomized traffic with a narrow register window for collisions.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            pulse_reset();
         end else begin
            step(bit'($urandom_range(0, 9) < 7), int'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 5)),
                 2'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
                 2'($urandom_range(1, 3)));
         end
      end

      @(posedge clk); #1;
      idle_inputs();
      for (int k = 0; k < 10 && expq.size() > 0; k++) @(posedge clk);
      if (expq.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain pending=%0d expected=0", expq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
